// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch command/sequencing controller.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_RST  = 2'd0,
      ST_RUN  = 2'd1,
      ST_LAP  = 2'd2,
      ST_HALT = 2'd3
   } ctrl_state_e;

   typedef enum logic [1:0] {
      SC_SCAN     = 2'd0,
      SC_DEBOUNCE = 2'd1,
      SC_RELEASE  = 2'd2
   } scan_state_e;

   localparam logic [3:0] KEY_A = 4'hA;
   localparam logic [3:0] KEY_B = 4'hB;
   localparam logic [3:0] KEY_C = 4'hC;
   localparam logic [3:0] KEY_D = 4'hD;
   localparam logic [3:0] KEY_E = 4'hE;
   localparam logic [3:0] KEY_F = 4'hF;

   localparam logic [3:0] ROWS_IDLE = 4'hF;
   localparam logic [3:0] COL_RESET = 4'b1110;

   // Active-low column drive for column index col.
   function automatic logic [3:0] col_drive(input logic [1:0] col);
      return ~(4'b0001 << col);
   endfunction

   // Lowest-index active-low row wins when several are down.
   function automatic logic [1:0] lowest_row(input logic [3:0] pat);
      if (!pat[0])      return 2'd0;
      else if (!pat[1]) return 2'd1;
      else if (!pat[2]) return 2'd2;
      else              return 2'd3;
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] col, input logic [1:0] row);
      if (col == 2'd3) begin
         return KEY_A + {2'b00, row};
      end else if (row == 2'd3) begin
         case (col)
            2'd0:    return KEY_E;
            2'd1:    return 4'h0;
            default: return KEY_F;
         endcase
      end else begin
         return 4'({2'b00, row} * 4'd3 + {2'b00, col} + 4'd1);
      end
   endfunction

endpackage

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row synchronizer, column scan, debounce and key decode.
module keypad_scanner
   import stopwatch_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES     = 500000,
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] linhas,
   output logic [3:0] colunas,
   output logic [3:0] key_code,
   output logic       key_valid
);

   localparam int unsigned CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
   localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   scan_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       col_q, col_d;
   logic [3:0]       pat_q, pat_d;
   logic [3:0]       code_q, code_d;
   logic             valid_q, valid_d;
   logic [3:0]       colunas_q;
   logic [3:0]       sync1_q, rs_q;

   // Two-flop synchronizer on the asynchronous row inputs.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= ROWS_IDLE;
         rs_q    <= ROWS_IDLE;
      end else begin
         sync1_q <= linhas;
         rs_q    <= sync1_q;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= SC_SCAN;
         cnt_q     <= '0;
         col_q     <= 2'd0;
         pat_q     <= ROWS_IDLE;
         code_q    <= 4'h0;
         valid_q   <= 1'b0;
         colunas_q <= COL_RESET;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         col_q     <= col_d;
         pat_q     <= pat_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         colunas_q <= col_drive(col_d);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      col_d   = col_q;
      pat_d   = pat_q;
      code_d  = code_q;
      valid_d = 1'b0;
      case (state_q)
         SC_SCAN: begin
            if (rs_q != ROWS_IDLE) begin
               pat_d   = rs_q;
               cnt_d   = '0;
               state_d = SC_DEBOUNCE;
            end else if (cnt_q == SCAN_LAST) begin
               cnt_d = '0;
               col_d = col_q + 2'd1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SC_DEBOUNCE: begin
            if (rs_q == ROWS_IDLE) begin
               cnt_d   = '0;
               state_d = SC_SCAN;
            end else if (rs_q != pat_q) begin
               pat_d = rs_q;
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               valid_d = 1'b1;
               code_d  = key_map(col_q, lowest_row(pat_q));
               cnt_d   = '0;
               state_d = SC_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SC_RELEASE: begin
            // Only a continuous all-high stretch counts as a release.
            if (rs_q != ROWS_IDLE) begin
               cnt_d = '0;
            end else if (cnt_q == DEB_LAST) begin
               cnt_d   = '0;
               state_d = SC_SCAN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = SC_SCAN;
         end
      endcase
   end

   assign colunas   = colunas_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: keypad front end, RST/RUN/LAP/HALT control FSM and gated 10 Hz tick.
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned SCAN_CYCLES     = 500000,
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned TICK_CYCLES     = 5000000
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] linhas,
   output logic [3:0] colunas,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic [1:0] curr_state,
   output logic       clear,
   output logic       count_en,
   output logic       freeze,
   output logic       tick,
   output logic [3:0] led_state
);

   localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);

   logic [3:0]  kp_code;
   logic        kp_valid;

   ctrl_state_e state_q, state_d;
   logic        clear_q, count_en_q, freeze_q, tick_q, tick_d;
   logic [3:0]  led_q;
   logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

   keypad_scanner #(
      .SCAN_CYCLES     (SCAN_CYCLES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_scanner (
      .clock     (clock),
      .reset_n   (reset_n),
      .linhas    (linhas),
      .colunas   (colunas),
      .key_code  (kp_code),
      .key_valid (kp_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_RST;
         clear_q    <= 1'b1;
         count_en_q <= 1'b0;
         freeze_q   <= 1'b0;
         led_q      <= 4'b0001;
         tick_cnt_q <= '0;
         tick_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         clear_q    <= (state_d == ST_RST);
         count_en_q <= (state_d == ST_RUN) || (state_d == ST_LAP);
         freeze_q   <= (state_d == ST_LAP);
         led_q      <= 4'b0001 << state_d;
         tick_cnt_q <= tick_cnt_d;
         tick_q     <= tick_d;
      end
   end

   // Control FSM reacts only to command keys on an accepted key event.
   always_comb begin
      state_d = state_q;
      if (kp_valid) begin
         case (kp_code)
            KEY_A: state_d = ST_RST;
            KEY_B: state_d = ST_RUN;
            KEY_C: if (state_q == ST_RUN) state_d = ST_LAP;
            KEY_D: if ((state_q == ST_RUN) || (state_q == ST_LAP)) state_d = ST_HALT;
            default: ;
         endcase
      end
   end

   // Prescaler holds its phase while disabled so HALT->RUN resumes mid-period.
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      tick_d     = 1'b0;
      if (clear_q) begin
         tick_cnt_d = '0;
      end else if (count_en_q) begin
         if (tick_cnt_q == TICK_LAST) begin
            tick_cnt_d = '0;
            tick_d     = 1'b1;
         end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
         end
      end
   end

   assign key_code   = kp_code;
   assign key_valid  = kp_valid;
   assign curr_state = state_q;
   assign clear      = clear_q;
   assign count_en   = count_en_q;
   assign freeze     = freeze_q;
   assign tick       = tick_q;
   assign led_state  = led_q;

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Command and sequencing controller for the decisecond stopwatch datapath. It scans the 4x4 matrix keypad, debounces it, and decodes keys into one-cycle key events. Keys A/B/C/D drive a four-state control FSM. The block issues clear, count-enable, display-freeze and a gated 10 Hz tick, which the stopwatch counter/display datapath consumes directly.

## Interface
Parameters:
- `SCAN_CYCLES`, default 500000: clock cycles spent on each column while no key is down.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles needed to accept a press or a release.
- `TICK_CYCLES`, default 5000000: clock cycles per tick pulse (0.1 s at 50 MHz).

Ports:
- `clock` in 1: single system clock; all logic is on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `linhas` in 4: keypad row inputs, active-low, asynchronous to `clock`.
- `colunas` out 4: column drive, exactly one bit low.
- `key_code` out 4: code of the last accepted key.
- `key_valid` out 1: one-cycle pulse when a key is accepted.
- `curr_state` out 2: FSM state (RST=0, RUN=1, LAP=2, HALT=3).
- `clear` out 1: datapath synchronous clear; high in RST.
- `count_en` out 1: high in RUN and LAP.
- `freeze` out 1: high in LAP; the display holds its value while counting continues.
- `tick` out 1: one-cycle pulse every `TICK_CYCLES` cycles while `count_en` is high.
- `led_state` out 4: one-hot state indicator (bit n set for state n).

## Operation
- Row synchronizer: two flops on `linhas`; all logic uses the synchronized value `rs`.
- Column drive: index k drives `colunas[k]` low (k=0 gives 4'b1110; k=3 gives 4'b0111).
- Key map, rows 0..3:
  - col0: 1, 4, 7, E
  - col1: 2, 5, 8, 0
  - col2: 3, 6, 9, F
  - col3: A, B, C, D (codes 10..13)
- Simultaneous rows low: the lowest row index wins.
- Scanner FSM:
  - SCAN: a counter runs and the column index advances (3 wraps to 0) when the counter reaches `SCAN_CYCLES`-1. If `rs` != 4'hF, latch the pattern, clear the counter, hold the column, go to DEBOUNCE.
  - DEBOUNCE: if `rs` matches the latched pattern, count. If `rs` == 4'hF, return to SCAN with no event. If `rs` differs but is not all-high, relatch and restart the count. When the count reaches `DEBOUNCE_CYCLES`-1, pulse `key_valid`, update `key_code`, go to RELEASE.
  - RELEASE: count consecutive cycles with `rs` == 4'hF; any low row restarts the count. After `DEBOUNCE_CYCLES` such cycles, return to SCAN on the same column. A held key produces exactly one event.
- Control FSM, evaluated only on a `key_valid` cycle with key_code A..D:
  - A: RUN, LAP or HALT go to RST; RST stays RST.
  - B: RST, LAP or HALT go to RUN.
  - C: RUN goes to LAP.
  - D: RUN or LAP go to HALT.
  - All other key/state combinations and all digit keys: no change.
- Tick prescaler:
  - Cleared while `clear` is high.
  - Counts while `count_en` is high and holds in HALT.
  - At `TICK_CYCLES`-1: pulses `tick` and wraps to 0.

## Timing
- Reset values:
  - `colunas`=4'b1110, `key_code`=0, `key_valid`=0.
  - `curr_state`=RST, `clear`=1, `count_en`=0, `freeze`=0, `tick`=0, `led_state`=4'b0001.
  - Scanner in SCAN with all counters 0.
- Press latency: a row edge at the pins causes `key_valid` 2 (sync) + 1 (detect) + `DEBOUNCE_CYCLES` cycles later.
- Control outputs (`curr_state`, `clear`, `count_en`, `freeze`, `led_state`) are registered and change on the cycle after `key_valid`.
- `tick` is registered. The first tick after RST→RUN comes `TICK_CYCLES` cycles after `count_en` rises.
- LAP↔RUN does not disturb the prescaler phase. HALT→RUN resumes from the held count.
- Reset asserted mid-debounce or mid-count: all state returns to reset values immediately. No `key_valid` is emitted for a press in progress.

## Structure
- Package `stopwatch_pkg` holds:
  - control state enum (RST/RUN/LAP/HALT)
  - scanner state enum
  - key code constants KEY_A..KEY_D, KEY_E, KEY_F
  - column drive patterns
- Sub-module `keypad_scanner` contains the synchronizer, the scanner FSM, the key map, and the `key_code`/`key_valid` outputs.
- The top level holds the control FSM, the output decode and the tick prescaler.

## Test plan
All scenarios use SCAN_CYCLES=8, DEBOUNCE_CYCLES=4, TICK_CYCLES=10.
- Reset, then idle with `linhas`=4'hF: `colunas` cycles 1110→1101→1011→0111 every 8 cycles; `key_valid` never asserts; `clear`=1.
- Hold row1 low while col3 is active: `key_valid` pulses once with `key_code`=11 (B); next cycle `curr_state`=RUN, `count_en`=1; `tick` every 10 cycles.
- Press C then D: `freeze`=1 in LAP with ticks continuing; in HALT, `tick` stops and `count_en`=0. Press B: ticks resume with the prescaler phase preserved.
- Bounce: row low for 2 cycles, high, low for 2 cycles: no event. Hold key 5 for 20 cycles: exactly one event, `key_code`=5; state unchanged.
- Rows 0 and 2 low together on col1: `key_code`=2. Pulse `reset_n` low mid-DEBOUNCE: all outputs return to reset values and no `key_valid` is emitted.
